// File: rtl/coord_dispatcher.sv
// Frame coordinate dispatcher: walks a WxH raster in batches of NUM_ENGINES
// consecutive pixels and presents one (x,y) pair per engine lane.
module coord_dispatcher #(
  parameter int COORD_WIDTH = 16,
  parameter int NUM_ENGINES = 30,
  parameter int MAX_WIDTH   = 1280,
  parameter int MAX_HEIGHT  = 720
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   continuous,
  input  logic [COORD_WIDTH-1:0] cfg_width,
  input  logic [COORD_WIDTH-1:0] cfg_height,
  input  logic                   batch_ready,
  output logic                   batch_valid,
  output logic [COORD_WIDTH-1:0] x [NUM_ENGINES],
  output logic [COORD_WIDTH-1:0] y [NUM_ENGINES],
  output logic [NUM_ENGINES-1:0] lane_valid,
  output logic                   frame_done,
  output logic                   cfg_error,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int CW1 = COORD_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [COORD_WIDTH-1:0] x0, y0, w, h;
  logic                   cont;

  logic [COORD_WIDTH-1:0] lx [NUM_ENGINES];
  logic [COORD_WIDTH-1:0] ly [NUM_ENGINES];
  logic [CW1-1:0]         nsum;
  logic                   nwrap;
  logic [COORD_WIDTH-1:0] nx, ny;
  logic                   cfg_ok;
  logic                   last_batch;

  assign busy        = (state == RUN);
  assign batch_valid = busy;

  // NUM_ENGINES <= W guarantees a single subtraction is enough to wrap a row
  for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_lane
    logic [CW1-1:0] sum;
    logic           wrap;
    assign sum  = {1'b0, x0} + CW1'(gi);
    assign wrap = (sum >= {1'b0, w});
    assign lx[gi] = wrap ? COORD_WIDTH'(sum - {1'b0, w}) : COORD_WIDTH'(sum);
    assign ly[gi] = wrap ? y0 + COORD_WIDTH'(1) : y0;
    assign lane_valid[gi] = busy && (ly[gi] < h);
    assign x[gi] = lane_valid[gi] ? lx[gi] : '0;
    assign y[gi] = lane_valid[gi] ? ly[gi] : '0;
  end

  assign nsum  = {1'b0, x0} + CW1'(NUM_ENGINES);
  assign nwrap = (nsum >= {1'b0, w});
  assign nx    = nwrap ? COORD_WIDTH'(nsum - {1'b0, w}) : COORD_WIDTH'(nsum);
  assign ny    = nwrap ? y0 + COORD_WIDTH'(1) : y0;

  assign cfg_ok = (cfg_width >= COORD_WIDTH'(NUM_ENGINES)) &&
                  (cfg_width <= COORD_WIDTH'(MAX_WIDTH)) &&
                  (cfg_height != '0) &&
                  (cfg_height <= COORD_WIDTH'(MAX_HEIGHT));

  // Lanes are raster-ordered, so an invalid lane always shows up in the last one
  assign last_batch = !lane_valid[NUM_ENGINES-1] ||
                      ((ly[NUM_ENGINES-1] == h - COORD_WIDTH'(1)) &&
                       (lx[NUM_ENGINES-1] == w - COORD_WIDTH'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x0          <= '0;
      y0          <= '0;
      w           <= '0;
      h           <= '0;
      cont        <= 1'b0;
      frame_done  <= 1'b0;
      cfg_error   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      cfg_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w     <= cfg_width;
              h     <= cfg_height;
              cont  <= continuous;
              x0    <= '0;
              y0    <= '0;
              state <= RUN;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            x0    <= '0;
            y0    <= '0;
          end else if (batch_ready) begin
            if (last_batch) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              x0          <= '0;
              y0          <= '0;
              state       <= cont ? RUN : IDLE;
            end else begin
              x0 <= nx;
              y0 <= ny;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coord_dispatcher.sv
// Scoreboard bench for coord_dispatcher with four engine lanes.
module tb_coord_dispatcher;

  localparam int CW = 16;
  localparam int NE = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           continuous = 1'b0;
  logic [CW-1:0]  cfg_width = '0;
  logic [CW-1:0]  cfg_height = '0;
  logic           batch_ready = 1'b0;
  logic           batch_valid;
  logic [CW-1:0]  x [NE];
  logic [CW-1:0]  y [NE];
  logic [NE-1:0]  lane_valid;
  logic           frame_done;
  logic           cfg_error;
  logic [15:0]    frame_count;
  logic           busy;

  coord_dispatcher #(
    .COORD_WIDTH(CW), .NUM_ENGINES(NE), .MAX_WIDTH(1280), .MAX_HEIGHT(720)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .continuous(continuous), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .batch_ready(batch_ready), .batch_valid(batch_valid), .x(x), .y(y),
    .lane_valid(lane_valid), .frame_done(frame_done), .cfg_error(cfg_error),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] xs;
    logic [63:0] ys;
    logic [3:0]  lv;
  } batch_t;

  batch_t sb[$];
  int     checks = 0;
  int     failures = 0;
  int     exp_fc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: linear pixel index p+i mapped by division, independent of the wrap logic
  function automatic batch_t model(input int p, input int w, input int h);
    batch_t b;
    b = '0;
    for (int i = 0; i < NE; i++) begin
      if (p + i < w * h) begin
        b.xs[i*16 +: 16] = 16'((p + i) % w);
        b.ys[i*16 +: 16] = 16'((p + i) / w);
        b.lv[i]          = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic compare_batch(input string tag, input batch_t e);
    logic [63:0] gx, gy;
    for (int i = 0; i < NE; i++) begin
      gx[i*16 +: 16] = x[i];
      gy[i*16 +: 16] = y[i];
    end
    check({tag, "_x"}, gx, e.xs);
    check({tag, "_y"}, gy, e.ys);
    check({tag, "_lv"}, 64'(lane_valid), 64'(e.lv));
  endtask

  task automatic start_frame(input int w, input int h, input bit cont);
    @(negedge clk);
    cfg_width = 16'(w); cfg_height = 16'(h); continuous = cont;
    start = 1'b1; batch_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int w, input int h, input bit cont, input int ntx,
                     input int stall_at, input int stall_len, input int exp_done);
    int p = 0, tx = 0, budget = 0, done_cnt = 0, stall_left = stall_len;
    batch_t b;
    for (int k = 0; k < ntx; k++) begin
      sb.push_back(model(p, w, h));
      p += NE;
      if (p >= w * h) p = 0;
    end
    start_frame(w, h, cont);
    while (tx < ntx && budget < 200) begin
      budget++;
      if (frame_done) done_cnt++;
      if (tx == stall_at && stall_left > 0) begin
        batch_ready = 1'b0;
        stall_left--;
        compare_batch("hold", sb[0]);
      end else begin
        batch_ready = 1'b1;
        if (batch_valid) begin
          b = sb.pop_front();
          compare_batch("batch", b);
          $display("xfer w=%0d h=%0d #%0d lane0=(%0d,%0d) lv=%b", w, h, tx, x[0], y[0], lane_valid);
          tx++;
        end
      end
      @(negedge clk);
    end
    check("tx_timeout", 64'(tx), 64'(ntx));
    batch_ready = 1'b0;
    if (frame_done) done_cnt++;
    check("done_count", 64'(done_cnt), 64'(exp_done));
    exp_fc += exp_done;
    check("frame_count", 64'(frame_count), 64'(exp_fc));
    check("busy_after", 64'(busy), 64'(cont));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("busy_idle", 64'(busy), 64'd0);
    sb.delete();
  endtask

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bv", 64'(batch_valid), 64'd0);
    check("rst_lv", 64'(lane_valid), 64'd0);
    check("rst_fc", 64'(frame_count), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_cfgerr", 64'(cfg_error), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // single frame, then backpressure on the (4,0) batch, then continuous
    run(10, 3, 1'b0, 8, -1, 0, 1);
    run(10, 3, 1'b0, 8, 1, 5, 1);
    run(4, 2, 1'b1, 6, -1, 0, 3);

    // illegal width
    @(negedge clk);
    cfg_width = 16'd3; cfg_height = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfgerr_pulse", 64'(cfg_error), 64'd1);
    check("cfgerr_busy", 64'(busy), 64'd0);
    check("cfgerr_bv", 64'(batch_valid), 64'd0);
    @(negedge clk);
    check("cfgerr_clear", 64'(cfg_error), 64'd0);
    check("cfgerr_busy2", 64'(busy), 64'd0);

    // abort at base (4,0) with a simultaneous transfer
    start_frame(10, 3, 1'b0);
    compare_batch("abort_b0", model(0, 10, 3));
    @(negedge clk);
    compare_batch("abort_b1", model(4, 10, 3));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_bv", 64'(batch_valid), 64'd0);
    check("abort_done", 64'(frame_done), 64'd0);
    check("abort_fc", 64'(frame_count), 64'(exp_fc));

    // reset at base (8,2), observed before any clock edge
    start_frame(10, 3, 1'b0);
    for (int k = 0; k < 7; k++) @(negedge clk);
    compare_batch("pre_rst", model(28, 10, 3));
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_bv", 64'(batch_valid), 64'd0);
    compare_batch("arst", '0);
    check("arst_fc", 64'(frame_count), 64'd0);
    check("arst_done", 64'(frame_done), 64'd0);
    exp_fc = 0;
    batch_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run(4, 2, 1'b0, 2, -1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
